// File: rtl/px_record_drain_pkg.sv
// rtl/px_record_drain_pkg.sv - shared constants, record layout and state type for the pixel-record drain
// Purpose : frame geometry, 104-bit record field slices, escape marker,
//           drain FSM encoding and the escape-test helper.
// Ports   : none (package)
package px_record_drain_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 480;
   localparam int REC_W    = 104;

   // Record layout: {PxVal, Xval, Yval, Iteration}
   localparam int PX_HI = 103;
   localparam int PX_LO = 96;
   localparam int X_HI  = 95;
   localparam int X_LO  = 64;
   localparam int Y_HI  = 63;
   localparam int Y_LO  = 32;
   localparam int IT_HI = 31;
   localparam int IT_LO = 0;

   localparam logic [31:0] ESCAPED_MARK = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      RUN         = 1'b0,
      RESYNC_WAIT = 1'b1
   } drain_state_t;

   // The math stage marks an escaped pixel by saturating both coordinates.
   function automatic logic is_escaped(input logic [REC_W-1:0] rec);
      return (rec[X_HI:X_LO] == ESCAPED_MARK) && (rec[Y_HI:Y_LO] == ESCAPED_MARK);
   endfunction

endpackage

// File: rtl/px_record_drain_addr_counter.sv
// rtl/px_record_drain_addr_counter.sv - linear pixel address counter with frame wrap and pass-done pulse
// Purpose : counts pixels 0..N_PIX-1, wraps to 0 after the last pixel and
//           pulses o_Pass_Done the cycle after the wrapping step.
// Ports   : i_Clk, i_Reset (sync, active high)
//           i_Step      advance by one pixel
//           i_Clear     restart at pixel 0 (a wrap on the same step still pulses)
//           o_Addr      current pixel address
//           o_Wrap      combinational: this step is the last pixel of the frame
//           o_Pass_Done registered one-cycle pulse after a wrap
module px_addr_counter
   import px_record_drain_pkg::*;
#(
   parameter int ADDR_W = 19,
   parameter int N_PIX  = H_ACTIVE * V_ACTIVE
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_Step,
   input  logic              i_Clear,
   output logic [ADDR_W-1:0] o_Addr,
   output logic              o_Wrap,
   output logic              o_Pass_Done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

   logic [ADDR_W-1:0] r_addr;
   logic              r_pass_done;

   assign o_Wrap      = i_Step && (r_addr == LAST_ADDR);
   assign o_Addr      = r_addr;
   assign o_Pass_Done = r_pass_done;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_addr      <= '0;
         r_pass_done <= 1'b0;
      end else begin
         r_pass_done <= o_Wrap;
         if (i_Clear || o_Wrap) begin
            r_addr <= '0;
         end else if (i_Step) begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/px_record_drain.sv
// rtl/px_record_drain.sv - drains math-output pixel records into frame-store writes with pass statistics
// Purpose : pops show-ahead FIFO records into a one-entry holding register,
//           issues one addressed frame-store write per record, counts escaped
//           pixels per pass and flags convergence between passes.
// Ports   : i_Clk, i_Reset (sync, active high)
//           i_Fifo_Data/i_Fifo_Empty/o_Fifo_Rdack  FIFO head and pop
//           o_Mem_Valid/i_Mem_Ready/o_Mem_Addr/o_Mem_Data  frame-store write
//           i_Resync      restart addressing at pixel 0
//           o_Pass_Done   pulse after the last pixel of a pass is written
//           o_Pass_Count  completed passes (saturating)
//           o_Last_Escaped escaped count of the latest completed pass
//           o_Converged   two consecutive passes had equal nonzero escaped counts
module px_record_drain #(
   parameter int H_ACTIVE = px_record_drain_pkg::H_ACTIVE,
   parameter int V_ACTIVE = px_record_drain_pkg::V_ACTIVE,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 104,
   parameter int PASS_W   = 16
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic [DATA_W-1:0] i_Fifo_Data,
   input  logic              i_Fifo_Empty,
   output logic              o_Fifo_Rdack,
   output logic              o_Mem_Valid,
   input  logic              i_Mem_Ready,
   output logic [ADDR_W-1:0] o_Mem_Addr,
   output logic [DATA_W-1:0] o_Mem_Data,
   input  logic              i_Resync,
   output logic              o_Pass_Done,
   output logic [PASS_W-1:0] o_Pass_Count,
   output logic [ADDR_W-1:0] o_Last_Escaped,
   output logic              o_Converged
);
   import px_record_drain_pkg::*;

   drain_state_t      r_state;
   logic              r_mem_valid;
   logic [DATA_W-1:0] r_mem_data;
   logic [ADDR_W-1:0] r_run_esc;
   logic [ADDR_W-1:0] r_last_esc;
   logic [PASS_W-1:0] r_pass_count;
   logic              r_converged;

   logic              w_beat;
   logic              w_rdack;
   logic              w_clear;
   logic              w_wrap;
   logic              w_esc_beat;
   logic [ADDR_W-1:0] w_new_last;

   assign w_beat  = r_mem_valid && i_Mem_Ready;
   assign w_rdack = !i_Fifo_Empty && (!r_mem_valid || i_Mem_Ready) && (r_state == RUN);

   // A resync may only restart addressing once no record is left waiting for
   // its old address; a stalled request defers it to its own beat.
   assign w_clear = ((r_state == RUN) && i_Resync && (!r_mem_valid || i_Mem_Ready)) ||
                    ((r_state == RESYNC_WAIT) && w_beat);

   assign w_esc_beat = w_beat && is_escaped(r_mem_data);
   assign w_new_last = r_run_esc + ADDR_W'(w_esc_beat);

   px_addr_counter #(
      .ADDR_W (ADDR_W),
      .N_PIX  (H_ACTIVE * V_ACTIVE)
   ) u_addr (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Step      (w_beat),
      .i_Clear     (w_clear),
      .o_Addr      (o_Mem_Addr),
      .o_Wrap      (w_wrap),
      .o_Pass_Done (o_Pass_Done)
   );

   assign o_Fifo_Rdack   = w_rdack;
   assign o_Mem_Valid    = r_mem_valid;
   assign o_Mem_Data     = r_mem_data;
   assign o_Pass_Count   = r_pass_count;
   assign o_Last_Escaped = r_last_esc;
   assign o_Converged    = r_converged;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state      <= RUN;
         r_mem_valid  <= 1'b0;
         r_mem_data   <= '0;
         r_run_esc    <= '0;
         r_last_esc   <= '0;
         r_pass_count <= '0;
         r_converged  <= 1'b0;
      end else begin
         if (w_rdack) begin
            r_mem_data  <= i_Fifo_Data;
            r_mem_valid <= 1'b1;
         end else if (w_beat) begin
            r_mem_valid <= 1'b0;
         end

         case (r_state)
            RUN:         if (i_Resync && r_mem_valid && !i_Mem_Ready) r_state <= RESYNC_WAIT;
            RESYNC_WAIT: if (w_beat) r_state <= RUN;
            default:     r_state <= RUN;
         endcase

         // A wrap closes the pass even when a resync lands on the same beat.
         if (w_wrap) begin
            r_last_esc  <= w_new_last;
            r_run_esc   <= '0;
            r_converged <= (w_new_last == r_last_esc) && (w_new_last != '0) &&
                           (r_pass_count != '0);
            if (r_pass_count != '1) r_pass_count <= r_pass_count + 1'b1;
         end else if (w_clear) begin
            r_run_esc   <= '0;
            r_converged <= 1'b0;
         end else if (w_esc_beat) begin
            r_run_esc <= r_run_esc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_px_record_drain.sv
// tb/tb_px_record_drain.sv - directed self-checking bench for px_record_drain
module tb_px_record_drain;

   localparam int H    = 8;
   localparam int V    = 4;
   localparam int NPIX = H * V;
   localparam int AW   = 19;
   localparam int DW   = 104;
   localparam int PW   = 16;

   logic          clk = 1'b0;
   logic          i_Reset;
   logic [DW-1:0] i_Fifo_Data;
   logic          i_Fifo_Empty;
   logic          o_Fifo_Rdack;
   logic          o_Mem_Valid;
   logic          i_Mem_Ready;
   logic [AW-1:0] o_Mem_Addr;
   logic [DW-1:0] o_Mem_Data;
   logic          i_Resync;
   logic          o_Pass_Done;
   logic [PW-1:0] o_Pass_Count;
   logic [AW-1:0] o_Last_Escaped;
   logic          o_Converged;

   always #5 clk = ~clk;

   px_record_drain #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .PASS_W   (PW)
   ) dut (
      .i_Clk          (clk),
      .i_Reset        (i_Reset),
      .i_Fifo_Data    (i_Fifo_Data),
      .i_Fifo_Empty   (i_Fifo_Empty),
      .o_Fifo_Rdack   (o_Fifo_Rdack),
      .o_Mem_Valid    (o_Mem_Valid),
      .i_Mem_Ready    (i_Mem_Ready),
      .o_Mem_Addr     (o_Mem_Addr),
      .o_Mem_Data     (o_Mem_Data),
      .i_Resync       (i_Resync),
      .o_Pass_Done    (o_Pass_Done),
      .o_Pass_Count   (o_Pass_Count),
      .o_Last_Escaped (o_Last_Escaped),
      .o_Converged    (o_Converged)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            exp_addr    = 0;
   logic          pd_exp      = 1'b0;
   logic          resync_pend = 1'b0;
   int            pd_seen     = 0;
   logic [15:0]   rd_trace    = '0;
   logic [15:0]   v_trace     = '0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_rec(input int i, input bit esc);
      logic [31:0] x, y;
      x = esc ? 32'hFFFF_FFFF : 32'(i * 7 + 3);
      y = esc ? 32'hFFFF_FFFF : 32'(i * 13 + 1);
      return {8'(i + 1), x, y, 32'(i + 100)};
   endfunction

   task automatic drive_fifo();
      i_Fifo_Empty = (fifo_q.size() == 0);
      i_Fifo_Data  = i_Fifo_Empty ? '0 : fifo_q[0];
   endtask

   task automatic push(input logic [DW-1:0] rec);
      fifo_q.push_back(rec);
      exp_q.push_back(rec);
      drive_fifo();
   endtask

   // One clock: sample at the falling edge, score any beat, pop at the rising edge.
   task automatic cycle();
      logic rd, bt;
      @(negedge clk);
      rd = o_Fifo_Rdack;
      bt = o_Mem_Valid && i_Mem_Ready;
      chk("pass_done", o_Pass_Done, pd_exp);
      if (o_Pass_Done) pd_seen++;
      if (bt) begin
         chk("beat_addr", o_Mem_Addr, exp_addr);
         chk("beat_has_record", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("beat_data", o_Mem_Data, exp_q.pop_front());
         pd_exp      = (exp_addr == NPIX - 1);
         exp_addr    = (resync_pend || exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
         resync_pend = 1'b0;
      end else begin
         pd_exp = 1'b0;
      end
      rd_trace = {rd_trace[14:0], rd};
      v_trace  = {v_trace[14:0], o_Mem_Valid};
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   // Push one full pass with n_esc escaped pixels and drain it.
   task automatic run_pass(input int n_esc, input bit stall, input int want_last,
                           input int want_count, input bit want_conv);
      int guard;
      for (int i = 0; i < NPIX; i++) push(mk_rec(i, (i % 3 == 0) && (i / 3 < n_esc)));
      pd_seen = 0;
      guard   = 0;
      while ((fifo_q.size() != 0 || o_Mem_Valid) && guard < 400) begin
         i_Mem_Ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         cycle();
         guard++;
      end
      i_Mem_Ready = 1'b1;
      chk("pass_timeout", guard < 400, 1);
      cycle();
      chk("pass_done_pulses", pd_seen, 1);
      chk("last_escaped", o_Last_Escaped, want_last);
      chk("pass_count", o_Pass_Count, want_count);
      chk("converged", o_Converged, want_conv);
      chk("addr_wrapped", o_Mem_Addr, 0);
   endtask

   initial begin
      int guard;
      i_Reset     = 1'b1;
      i_Mem_Ready = 1'b0;
      i_Resync    = 1'b0;
      drive_fifo();
      repeat (3) @(posedge clk);
      #1;
      i_Reset = 1'b0;

      // Idle after reset with an empty FIFO
      repeat (10) cycle();
      chk("idle_rdack_trace", rd_trace[9:0], 10'b0);
      chk("rst_valid", o_Mem_Valid, 0);
      chk("rst_addr", o_Mem_Addr, 0);
      chk("rst_data", o_Mem_Data, 0);
      chk("rst_pass_count", o_Pass_Count, 0);
      chk("rst_last_esc", o_Last_Escaped, 0);
      chk("rst_converged", o_Converged, 0);

      // Four records back to back with ready high
      i_Mem_Ready = 1'b1;
      for (int i = 0; i < 4; i++) push(mk_rec(i, 1'b0));
      repeat (6) cycle();
      chk("rdack_pattern", rd_trace[5:0], 6'b111100);
      chk("valid_pattern", v_trace[5:0], 6'b011110);
      chk("four_drained", exp_q.size(), 0);
      chk("addr_after_four", o_Mem_Addr, 4);

      // Stall three cycles with the FIFO non-empty
      i_Mem_Ready = 1'b0;
      for (int i = 4; i < 7; i++) push(mk_rec(i, 1'b0));
      cycle();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_rdack", o_Fifo_Rdack, 0);
         chk("stall_valid", o_Mem_Valid, 1);
         chk("stall_addr", o_Mem_Addr, exp_addr);
         chk("stall_data", o_Mem_Data, exp_q[0]);
         cycle();
      end
      i_Mem_Ready = 1'b1;
      repeat (5) cycle();
      chk("stall_drained", exp_q.size(), 0);
      chk("addr_after_stall", o_Mem_Addr, 7);

      // Idle resync restarts addressing
      i_Resync = 1'b1;
      cycle();
      i_Resync = 1'b0;
      exp_addr = 0;
      chk("idle_resync_addr", o_Mem_Addr, 0);

      // Three full passes: 10, 10, 9 escaped
      run_pass(10, 1'b0, 10, 1, 1'b0);
      run_pass(10, 1'b1, 10, 2, 1'b1);
      run_pass(9,  1'b1, 9,  3, 1'b0);

      // Resync during a stall at pixel 17
      for (int i = 0; i < 18; i++) push(mk_rec(i, (i == 2) || (i == 5) || (i == 9)));
      for (int i = 0; i < NPIX; i++) push(mk_rec(i + 50, (i % 4 == 1) && (i < 20)));
      pd_seen = 0;
      guard   = 0;
      while (!(o_Mem_Valid && o_Mem_Addr == 17) && guard < 100) begin
         cycle();
         guard++;
      end
      chk("reach_addr17", guard < 100, 1);
      i_Mem_Ready = 1'b0;
      i_Resync    = 1'b1;
      cycle();
      i_Resync = 1'b0;
      #1;
      chk("resync_wait_rdack", o_Fifo_Rdack, 0);
      chk("resync_wait_addr", o_Mem_Addr, 17);
      cycle();
      i_Mem_Ready = 1'b1;
      #1;
      chk("resync_beat_rdack", o_Fifo_Rdack, 0);
      resync_pend = 1'b1;
      cycle();
      chk("resync_addr0", o_Mem_Addr, 0);
      chk("resync_pass_count", o_Pass_Count, 3);
      chk("resync_converged", o_Converged, 0);
      guard = 0;
      while ((fifo_q.size() != 0 || o_Mem_Valid) && guard < 200) begin
         cycle();
         guard++;
      end
      chk("resync_drain_timeout", guard < 200, 1);
      cycle();
      chk("resync_pass_pulses", pd_seen, 1);
      chk("resync_last_esc", o_Last_Escaped, 5);
      chk("resync_pass_count4", o_Pass_Count, 4);
      chk("resync_conv_after", o_Converged, 0);
      chk("all_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/px_record_drain.md
Name: px_record_drain

Overview:
- Reader side of the math-output pixel-record FIFO: pops 104-bit records written by the escape-time math stage and issues one frame-store write per record, with a linear pixel address.
- Tracks pass (full-frame sweep) boundaries, counts escaped pixels per pass, and flags convergence.
- Sits between the math-output FIFO and the frame-store write port; the frame store later re-feeds the math-input FIFO.

Parameters:
- H_ACTIVE, 800, pixels per line.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- DATA_W, 104, record width: {PxVal[7:0], Xval[31:0], Yval[31:0], Iteration[31:0]}.
- PASS_W, 16, pass counter width.

Ports:
- i_Clk, in, 1, sole clock.
- i_Reset, in, 1, synchronous active-high reset.
- i_Fifo_Data, in, DATA_W, show-ahead FIFO head; valid whenever i_Fifo_Empty=0.
- i_Fifo_Empty, in, 1, FIFO empty.
- o_Fifo_Rdack, out, 1, pop head this cycle.
- o_Mem_Valid, out, 1, write request valid.
- i_Mem_Ready, in, 1, frame store accepts the request.
- o_Mem_Addr, out, ADDR_W, linear pixel address, y*H_ACTIVE+x.
- o_Mem_Data, out, DATA_W, record to store, unmodified.
- i_Resync, in, 1, single-cycle pulse: restart addressing at pixel 0.
- o_Pass_Done, out, 1, one-cycle pulse when the last pixel of a pass is written.
- o_Pass_Count, out, PASS_W, completed passes; saturates at all-ones.
- o_Last_Escaped, out, ADDR_W, escaped-pixel count of the most recent completed pass.
- o_Converged, out, 1, two consecutive completed passes had equal nonzero escaped counts.

Behaviour:
- Reset values: o_Fifo_Rdack=0, o_Mem_Valid=0, o_Mem_Addr=0, o_Mem_Data=0, o_Pass_Done=0, o_Pass_Count=0, o_Last_Escaped=0, o_Converged=0. The state machine resets to RUN, and the running escaped count resets to 0.
- Holding register: one entry.
  - o_Fifo_Rdack = ~i_Fifo_Empty & (~o_Mem_Valid | i_Mem_Ready) & (state==RUN). This is combinational.
  - On Rdack, the head is loaded into o_Mem_Data and o_Mem_Valid=1 on the next edge. Latency is 1 cycle from pop to valid.
  - With the FIFO never empty and i_Mem_Ready held at 1, throughput is one record per clock.
- Beat: a transfer is o_Mem_Valid & i_Mem_Ready.
  - o_Mem_Addr, o_Mem_Data and o_Mem_Valid stay stable while o_Mem_Valid=1 and i_Mem_Ready=0.
  - If no new pop occurs in the beat cycle, o_Mem_Valid drops.
- Address:
  - Incremented by 1 on each beat.
  - A beat at address H_ACTIVE*V_ACTIVE-1 (383999) wraps the address to 0.
  - The same beat raises o_Pass_Done in the following cycle.
- Escape detection: a record is escaped iff Xval==32'hFFFFFFFF and Yval==32'hFFFFFFFF. The running count increments on each escaped beat.
- Pass end (wrapping beat):
  - o_Last_Escaped <= running count, including the wrapping beat's own contribution.
  - The running count clears to 0.
  - o_Pass_Count increments, saturating.
  - o_Converged <= (new value == previous o_Last_Escaped) & (new value != 0) & (o_Pass_Count >= 1).
- States:
  - RUN: normal operation.
    - i_Resync with o_Mem_Valid=0 or a beat this cycle: address <= 0, running count <= 0, o_Converged <= 0, stay in RUN. The beating record keeps its old address.
    - i_Resync with a stalled request: go to RESYNC_WAIT.
  - RESYNC_WAIT: Rdack is held at 0.
    - On the stalled beat: address <= 0, counters cleared as above, go to RUN.
- Simultaneous events:
  - Resync on a wrapping beat: o_Pass_Done still pulses and pass statistics still update. Address becomes 0, identical to a plain wrap.
  - Resync while in RESYNC_WAIT is ignored.
- o_Pass_Count is not cleared by resync.
- Reset mid-transfer drops the held record. The upstream FIFO is not flushed by this block.

Decomposition:
- Shared package/header (alongside draw.vh):
  - record field slice constants: PX 103:96, X 95:64, Y 63:32, IT 31:0.
  - ESCAPED_MARK=32'hFFFFFFFF.
  - H_ACTIVE, V_ACTIVE.
  - state encodings RUN, RESYNC_WAIT.
- One natural sub-module: px_addr_counter, containing the wrap counter plus pass-done pulse, with inputs i_Step and i_Clear. It is reusable by the frame-store reader that feeds the math-input FIFO.

Test Plan:
- Reset, FIFO empty, 10 cycles -> all outputs 0, Rdack never asserted.
- 4 records pushed, i_Mem_Ready=1 -> Rdack on 4 consecutive cycles; Mem_Valid 1 cycle later; addresses 0,1,2,3; data bit-identical to the records.
- Ready held low 3 cycles with FIFO non-empty -> Rdack=0 and addr/data frozen during the stall; then resume with no record lost or duplicated.
- Full pass of 384000 records, 1000 of them escaped (X=Y=FFFFFFFF) -> Pass_Done single pulse after the beat at addr 383999; address wraps to 0; Last_Escaped=1000; Pass_Count=1.
- Second pass also with 1000 escaped -> o_Converged=1. Third pass with 999 escaped -> o_Converged=0.
- Resync pulsed during a stall at addr 17 -> stalled beat completes at addr 17; next beat at addr 0; running count cleared; Pass_Count unchanged.
